// File: rtl/word_tx_queue_pkg.sv
// Shared types and constants for the transmit-side word queue.
// Byte-order helpers keep the serializer independent of MSB/LSB-first selection.
package word_tx_queue_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned IDX_W          = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_ACK,
        WAIT_DONE
    } tx_state_e;

    // Byte at the send end of the shift register
    function automatic logic [BYTE_W-1:0] lead_byte(input logic [WORD_W-1:0] w,
                                                    input logic              msb_first);
        return msb_first ? w[WORD_W-1 -: BYTE_W] : w[BYTE_W-1:0];
    endfunction

    // Move the next byte into the send position
    function automatic logic [WORD_W-1:0] advance(input logic [WORD_W-1:0] w,
                                                  input logic              msb_first);
        return msb_first ? (w << BYTE_W) : (w >> BYTE_W);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with extra-MSB pointers; count and not_full are registered,
// full/empty/head are decodes of the pointer registers.
module sync_fifo #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout_c,
    output logic                  full_c,
    output logic                  empty_c,
    output logic                  not_full,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr, rptr, wptr_nxt, rptr_nxt;
    logic             do_push, do_pop, full_nxt;

    always_comb begin
        full_c   = (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]) &&
                   (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]);
        empty_c  = (wptr == rptr);
        do_push  = push && !full_c;
        do_pop   = pop && !empty_c;
        wptr_nxt = wptr + PTR_W'(do_push);
        rptr_nxt = rptr + PTR_W'(do_pop);
        full_nxt = (wptr_nxt[DEPTH_LOG2] != rptr_nxt[DEPTH_LOG2]) &&
                   (wptr_nxt[DEPTH_LOG2-1:0] == rptr_nxt[DEPTH_LOG2-1:0]);
        dout_c   = mem[rptr[DEPTH_LOG2-1:0]];
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[DEPTH_LOG2-1:0]] <= din;
        end
    end

    // Occupancy flags track the post-update pointers so they line up with them
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            not_full <= 1'b1;
        end else begin
            wptr     <= wptr_nxt;
            rptr     <= rptr_nxt;
            count    <= wptr_nxt - rptr_nxt;
            not_full <= !full_nxt;
        end
    end

endmodule

// File: rtl/word_tx_queue.sv
// Transmit word queue: buffers 32-bit words from the core and feeds them to the
// UART sender one byte per ready/enable handshake.
module word_tx_queue
    import word_tx_queue_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 3,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic [WORD_W-1:0]    word_in,
    input  logic                 word_valid,
    output logic                 word_ready,
    output logic [BYTE_W-1:0]    byte_out,
    output logic                 byte_enable,
    input  logic                 sender_ready,
    output logic [DEPTH_LOG2:0]  count,
    output logic                 busy,
    output logic                 overflow
);

    tx_state_e          state, state_nxt;
    logic [WORD_W-1:0]  shreg, shreg_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [BYTE_W-1:0]  byte_out_nxt;
    logic               byte_enable_nxt, overflow_nxt, busy_nxt;
    logic               push, pop;
    logic [WORD_W-1:0]  head_c;
    logic               full_c, empty_c;

    sync_fifo #(
        .WIDTH      (WORD_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk      (CLK),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .din      (word_in),
        .dout_c   (head_c),
        .full_c   (full_c),
        .empty_c  (empty_c),
        .not_full (word_ready),
        .count    (count)
    );

    // Next-state, serializer and output logic
    always_comb begin
        state_nxt       = state;
        shreg_nxt       = shreg;
        idx_nxt         = idx;
        byte_out_nxt    = byte_out;
        byte_enable_nxt = 1'b0;
        pop             = 1'b0;
        push            = word_valid && !full_c;
        overflow_nxt    = overflow || (word_valid && full_c);

        case (state)
            IDLE: begin
                if (!empty_c) begin
                    pop       = 1'b1;
                    shreg_nxt = head_c;
                    idx_nxt   = '0;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                byte_out_nxt = lead_byte(shreg, MSB_FIRST);
                state_nxt    = SEND;
            end
            SEND: begin
                if (sender_ready) begin
                    byte_enable_nxt = 1'b1;
                    state_nxt       = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (!sender_ready) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (sender_ready) begin
                    if (idx == IDX_W'(BYTES_PER_WORD - 1)) begin
                        state_nxt = IDLE;
                    end else begin
                        shreg_nxt = advance(shreg, MSB_FIRST);
                        idx_nxt   = idx + IDX_W'(1);
                        state_nxt = LOAD;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A pop always leaves IDLE, so post-update occupancy is nonzero iff count or push is
        busy_nxt = (state_nxt != IDLE) || (count != '0) || push;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state       <= IDLE;
            shreg       <= '0;
            idx         <= '0;
            byte_out    <= '0;
            byte_enable <= 1'b0;
            overflow    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            shreg       <= shreg_nxt;
            idx         <= idx_nxt;
            byte_out    <= byte_out_nxt;
            byte_enable <= byte_enable_nxt;
            overflow    <= overflow_nxt;
            busy        <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_word_tx_queue.sv
// Bench for word_tx_queue: MSB-first and LSB-first instances share stimulus and a
// handshaking sender; a queue-based model predicts every output each cycle.
module tb_word_tx_queue;

    localparam int unsigned DL2   = 3;
    localparam int          DEPTH = 8;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] word_in = '0;
    logic        word_valid = 1'b0;
    logic        sender_ready = 1'b1;

    logic        word_ready_m, byte_enable_m, busy_m, overflow_m;
    logic [7:0]  byte_out_m;
    logic [3:0]  count_m;
    logic        word_ready_l, byte_enable_l, busy_l, overflow_l;
    logic [7:0]  byte_out_l;
    logic [3:0]  count_l;

    word_tx_queue #(.DEPTH_LOG2(DL2), .MSB_FIRST(1'b1)) dut_m (
        .CLK(CLK), .reset(reset), .word_in(word_in), .word_valid(word_valid),
        .word_ready(word_ready_m), .byte_out(byte_out_m), .byte_enable(byte_enable_m),
        .sender_ready(sender_ready), .count(count_m), .busy(busy_m), .overflow(overflow_m));

    word_tx_queue #(.DEPTH_LOG2(DL2), .MSB_FIRST(1'b0)) dut_l (
        .CLK(CLK), .reset(reset), .word_in(word_in), .word_valid(word_valid),
        .word_ready(word_ready_l), .byte_out(byte_out_l), .byte_enable(byte_enable_l),
        .sender_ready(sender_ready), .count(count_l), .busy(busy_l), .overflow(overflow_l));

    always #5 CLK = ~CLK;

    int checks = 0;
    int passed = 0;
    int unsigned cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model: words waiting, word in flight, and sender-handshake progress
    logic [31:0] mq[$];
    logic [31:0] cur = '0;
    bit          act = 1'b0, model_ok = 1'b0, m_en = 1'b0, m_ovf = 1'b0, m_rst = 1'b0;
    bit          pop_now = 1'b0, sender_clr = 1'b0;
    int          nsent = 0, hs = 0, pre = 0;
    int unsigned next_en = 0;
    logic [7:0]  m_byte_m = '0, m_byte_l = '0;

    always @(posedge CLK) begin
        cyc++;
        m_en  = 1'b0;
        m_rst = 1'b0;
        if (reset) begin
            mq.delete();
            act = 1'b0; hs = 0; nsent = 0; m_ovf = 1'b0;
            m_rst = 1'b1; model_ok = 1'b1; sender_clr = 1'b1;
        end else if (model_ok) begin
            pre     = mq.size();
            pop_now = !act && pre > 0;
            if (pop_now) begin
                cur = mq.pop_front();
                act = 1'b1; nsent = 0; hs = 0; next_en = cyc + 2;
            end
            if (word_valid) begin
                if (pre < DEPTH) mq.push_back(word_in);
                else m_ovf = 1'b1;
            end
            if (!pop_now && act) begin
                if (hs == 1) begin
                    if (!sender_ready) hs = 2;
                end else if (hs == 2) begin
                    if (sender_ready) begin
                        hs = 0;
                        if (nsent == 4) act = 1'b0;
                        else next_en = cyc + 2;
                    end
                end else if (cyc >= next_en && sender_ready) begin
                    m_en     = 1'b1;
                    m_byte_m = 8'(cur >> (24 - 8 * nsent));
                    m_byte_l = 8'(cur >> (8 * nsent));
                    nsent++;
                    hs = 1;
                end
            end
        end
    end

    logic [7:0]  log_m[$], log_l[$];
    int unsigned en_cyc[$];

    // Per-cycle comparison against the model, sampled mid-cycle
    always @(negedge CLK) begin
        if (model_ok) begin
            check("count",       32'(count_m),       32'(mq.size()));
            check("word_ready",  32'(word_ready_m),  32'(mq.size() < DEPTH));
            check("overflow",    32'(overflow_m),    32'(m_ovf));
            check("busy",        32'(busy_m),        32'(act || mq.size() != 0));
            check("byte_en_m",   32'(byte_enable_m), 32'(m_en));
            check("byte_en_l",   32'(byte_enable_l), 32'(m_en));
            if (m_en) begin
                check("byte_out_m", 32'(byte_out_m), 32'(m_byte_m));
                check("byte_out_l", 32'(byte_out_l), 32'(m_byte_l));
            end
            if (m_rst) begin
                check("rst_byte_m", 32'(byte_out_m), 32'(0));
                check("rst_byte_l", 32'(byte_out_l), 32'(0));
            end
            if (byte_enable_m) begin
                log_m.push_back(byte_out_m);
                log_l.push_back(byte_out_l);
                en_cyc.push_back(cyc);
            end
        end
    end

    // Sender: on enable, drops ready after a short delay, holds it low, then raises it
    int s_phase = 0, s_cnt = 0;
    bit stall = 1'b0, rand_lat = 1'b0;

    always @(negedge CLK) begin
        if (sender_clr) begin
            sender_clr   = 1'b0;
            s_phase      = 0;
            sender_ready = !stall;
        end else begin
            case (s_phase)
                0: begin
                    sender_ready = !stall;
                    if (byte_enable_m) begin
                        s_phase = 1;
                        s_cnt   = rand_lat ? int'($urandom_range(0, 3)) : 0;
                    end
                end
                1: begin
                    if (s_cnt == 0) begin
                        sender_ready = 1'b0;
                        s_phase      = 2;
                        s_cnt        = rand_lat ? int'($urandom_range(1, 40)) : 3;
                    end else s_cnt--;
                end
                2: begin
                    if (s_cnt == 0) begin
                        sender_ready = 1'b1;
                        s_phase      = 0;
                    end else s_cnt--;
                end
                default: s_phase = 0;
            endcase
        end
    end

    task automatic push_word(input logic [31:0] w);
        word_in = w; word_valid = 1'b1;
        @(negedge CLK);
        word_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
    endtask

    task automatic clear_logs();
        log_m.delete(); log_l.delete(); en_cyc.delete();
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((act || mq.size() != 0 || s_phase != 0) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check({name, "_timeout"}, 32'(n < budget), 32'(1));
        @(negedge CLK);
    endtask

    // Counts bytes of log_m that differ from words base..base+n-1 sent MSB first
    function automatic int order_errs(input logic [31:0] base, input int n);
        int errs = 0;
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = base + 32'(i);
            for (int k = 0; k < 4; k++) begin
                if (log_m[4 * i + k] !== 8'(w >> (24 - 8 * k))) errs++;
            end
        end
        return errs;
    endfunction

    initial begin
        int unsigned push_cyc;
        int n;

        repeat (2) @(negedge CLK);
        reset = 1'b0;
        check("rst_count",      32'(count_m),       32'(0));
        check("rst_word_ready", 32'(word_ready_m),  32'(1));
        check("rst_busy",       32'(busy_m),        32'(0));
        check("rst_overflow",   32'(overflow_m),    32'(0));
        check("rst_byte_en",    32'(byte_enable_m), 32'(0));

        // Single word, both byte orders
        clear_logs();
        push_cyc = cyc + 1;
        push_word(32'h1122_3344);
        wait_idle(200, "t1");
        check("t1_pulses", 32'(log_m.size()), 32'(4));
        if (log_m.size() == 4) begin
            check("t1_bytes_m", {log_m[0], log_m[1], log_m[2], log_m[3]}, 32'h1122_3344);
            check("t1_first_pulse", en_cyc[0], push_cyc + 3);
        end
        check("t1_busy_end", 32'(busy_m), 32'(0));

        clear_logs();
        push_word(32'hA1B2_C3D4);
        wait_idle(200, "t2");
        check("t2_pulses", 32'(log_l.size()), 32'(4));
        if (log_l.size() == 4)
            check("t2_bytes_l", {log_l[0], log_l[1], log_l[2], log_l[3]}, 32'hD4C3_B2A1);

        // Fill with sender stalled: one word in flight plus eight queued, then overflow
        do_reset();
        stall = 1'b1;
        repeat (2) @(negedge CLK);
        clear_logs();
        for (int i = 0; i < 9; i++) begin
            word_in = 32'h0000_0100 + 32'(i); word_valid = 1'b1;
            @(negedge CLK);
        end
        word_valid = 1'b0;
        check("t3_count_full",  32'(count_m),      32'(8));
        check("t3_ready_full",  32'(word_ready_m), 32'(0));
        check("t3_no_overflow", 32'(overflow_m),   32'(0));
        push_word(32'hBAD0_0001);
        check("t3_overflow",    32'(overflow_m),   32'(1));
        check("t3_count_held",  32'(count_m),      32'(8));
        stall = 1'b0;
        wait_idle(1500, "t3");
        check("t3_bytes", 32'(log_m.size()), 32'(36));
        if (log_m.size() == 36) check("t3_order", 32'(order_errs(32'h100, 9)), 32'(0));

        // Push on the pop edge while full is rejected; the next cycle's push is accepted
        do_reset();
        stall = 1'b1;
        repeat (2) @(negedge CLK);
        clear_logs();
        for (int i = 0; i < 9; i++) begin
            word_in = 32'h0000_0200 + 32'(i); word_valid = 1'b1;
            @(negedge CLK);
        end
        word_valid = 1'b0;
        check("t4_count_full", 32'(count_m),    32'(8));
        check("t4_ovf_clear",  32'(overflow_m), 32'(0));
        stall = 1'b0;
        n = 0;
        while (act && n < 500) begin @(negedge CLK); n++; end
        check("t4_wait_pop", 32'(n < 500), 32'(1));
        word_in = 32'hBAD0_0002; word_valid = 1'b1;
        @(negedge CLK);
        check("t4_ovf_on_pop", 32'(overflow_m), 32'(1));
        check("t4_count_pop",  32'(count_m),    32'(7));
        word_in = 32'h0000_0209;
        @(negedge CLK);
        word_valid = 1'b0;
        check("t4_count_refill", 32'(count_m),      32'(8));
        check("t4_ready_refill", 32'(word_ready_m), 32'(0));
        wait_idle(1500, "t4");
        check("t4_bytes", 32'(log_m.size()), 32'(40));
        if (log_m.size() == 40) check("t4_order", 32'(order_errs(32'h200, 10)), 32'(0));

        // Pointer wrap with random sender latency
        do_reset();
        rand_lat = 1'b1;
        clear_logs();
        for (int i = 0; i < 20; i++) begin
            n = 0;
            while (mq.size() >= DEPTH && n < 2000) begin @(negedge CLK); n++; end
            push_word(32'(i));
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end
        wait_idle(8000, "t5");
        check("t5_bytes", 32'(log_m.size()), 32'(80));
        if (log_m.size() == 80) check("t5_order", 32'(order_errs(32'h0, 20)), 32'(0));
        check("t5_count_end", 32'(count_m),    32'(0));
        check("t5_no_ovf",    32'(overflow_m), 32'(0));
        rand_lat = 1'b0;

        // Reset in the middle of a word with three words queued
        do_reset();
        clear_logs();
        push_word(32'hDEAD_BEEF);
        push_word(32'hAAAA_0001);
        push_word(32'hAAAA_0002);
        push_word(32'hAAAA_0003);
        n = 0;
        while (log_m.size() < 2 && n < 200) begin @(negedge CLK); n++; end
        check("t6_two_bytes", 32'(log_m.size()), 32'(2));
        check("t6_queued",    32'(count_m),      32'(3));
        do_reset();
        check("t6_rst_count", 32'(count_m),       32'(0));
        check("t6_rst_en",    32'(byte_enable_m), 32'(0));
        repeat (50) @(negedge CLK);
        check("t6_no_more", 32'(log_m.size()), 32'(2));
        push_word(32'h0102_0304);
        wait_idle(200, "t6");
        check("t6_bytes", 32'(log_m.size()), 32'(6));
        if (log_m.size() == 6) begin
            check("t6_new_m", {log_m[2], log_m[3], log_m[4], log_m[5]}, 32'h0102_0304);
            check("t6_new_l", {log_l[2], log_l[3], log_l[4], log_l[5]}, 32'h0403_0201);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
